// File: rtl/sum_ndigit_alu_if.sv
// Bus bundle for the digit-serial ALU.
// The master (button handler / bench) issues start/mode/operands.
// The slave (the ALU) returns status, the committed result and the 7-seg glyphs.
interface sum_ndigit_alu_if #(
    parameter int DIGITS = 4
) ();
    logic                  start;
    logic [1:0]            mode;
    logic [4*DIGITS-1:0]   operand_a;
    logic [4*DIGITS-1:0]   operand_b;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   result;
    logic                  overload;
    logic                  invalid;
    logic [7*DIGITS-1:0]   digits_result;

    modport master (
        output start, mode, operand_a, operand_b,
        input  busy, done, result, overload, invalid, digits_result
    );

    modport slave (
        input  start, mode, operand_a, operand_b,
        output busy, done, result, overload, invalid, digits_result
    );
endinterface

// File: rtl/sum_ndigit_alu.sv
// Digit-serial adder / subtractor / accumulator with hex or BCD digits.
// One digit is processed per clock, least significant digit first.
// The partial result builds up in a shadow register.
// It is committed to the visible result in one step, on the same edge that raises done.
// result and overload therefore never show an intermediate value.
module sum_ndigit_alu #(
    parameter int DIGITS = 4,
    parameter bit BCD    = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    sum_ndigit_alu_if.slave   bus
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_ACC = 2'b10;
    localparam logic [1:0] MODE_CLR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CALC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [W-1:0]    x_q, x_d;
    logic [W-1:0]    y_q, y_d;
    logic [W-1:0]    shadow_q, shadow_d;
    logic            cy_q, cy_d;        // carry (add/acc/clear) or borrow (sub)
    logic [CW-1:0]   cnt_q, cnt_d;      // index of the digit being processed
    logic            bad_q, bad_d;      // captured operands held a non-decimal digit
    logic [W-1:0]    result_q, result_d;
    logic            overload_q, overload_d;
    logic            invalid_q, invalid_d;

    // Operand selection and digit-validity flag for the LOAD cycle
    logic [W-1:0]    load_x, load_y;
    logic            load_bad;

    // Single-digit arithmetic on the low nibbles of x/y
    logic [4:0]      sum5, dif5;
    logic [3:0]      dig_val;
    logic            dig_cy;
    logic [W+3:0]    shadow_ext;

    logic [7*DIGITS-1:0] glyphs;

    // 7-seg glyph, segment bits {g,f,e,d,c,b,a}, active-high
    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Pick the x/y sources for the operation being loaded.
    // Accumulate folds the previous result back in as x.
    always_comb begin
        load_x = '0;
        load_y = '0;
        case (bus.mode)
            MODE_ADD, MODE_SUB: begin
                load_x = bus.operand_a;
                load_y = bus.operand_b;
            end
            MODE_ACC: begin
                load_x = result_q;
                load_y = bus.operand_a;
            end
            default: begin
                load_x = '0;
                load_y = '0;
            end
        endcase
    end

    // Flag any digit above 9 in the loaded operands; only meaningful for BCD
    always_comb begin
        load_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((load_x[4*i +: 4] > 4'd9) || (load_y[4*i +: 4] > 4'd9)) begin
                load_bad = 1'b1;
            end
        end
    end

    // One digit of add or subtract, with decimal correction when BCD is set
    always_comb begin
        sum5    = {1'b0, x_q[3:0]} + {1'b0, y_q[3:0]} + {4'b0, cy_q};
        dif5    = {1'b0, x_q[3:0]} - {1'b0, y_q[3:0]} - {4'b0, cy_q};
        dig_val = sum5[3:0];
        dig_cy  = sum5[4];
        if (mode_q == MODE_SUB) begin
            dig_val = dif5[3:0];
            dig_cy  = dif5[4];
            if (BCD && dif5[4]) begin
                dig_val = dif5[3:0] + 4'd10;
            end
        end else if (BCD && (sum5 > 5'd9)) begin
            dig_val = sum5[3:0] + 4'd6;
            dig_cy  = 1'b1;
        end
        shadow_ext = {dig_val, shadow_q};
    end

    // Next-state logic for the sequencer.
    // The last CALC cycle also commits result, overload and invalid.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        x_d        = x_q;
        y_d        = y_q;
        shadow_d   = shadow_q;
        cy_d       = cy_q;
        cnt_d      = cnt_q;
        bad_d      = bad_q;
        result_d   = result_q;
        overload_d = overload_q;
        invalid_d  = invalid_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                mode_d   = bus.mode;
                x_d      = load_x;
                y_d      = load_y;
                shadow_d = '0;
                cy_d     = 1'b0;
                cnt_d    = '0;
                bad_d    = BCD && load_bad;
                state_d  = S_CALC;
            end
            S_CALC: begin
                // Operands shift down so the active digit is always in bits [3:0].
                // Results shift in from the top, so after DIGITS cycles they are in place.
                x_d      = x_q >> 4;
                y_d      = y_q >> 4;
                shadow_d = shadow_ext[W+3:4];
                cy_d     = dig_cy;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_DIGIT) begin
                    state_d = S_DONE;
                    if (bad_q) begin
                        overload_d = 1'b0;
                        invalid_d  = 1'b1;
                    end else begin
                        result_d   = shadow_ext[W+3:4];
                        overload_d = dig_cy;
                        invalid_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mode_q     <= 2'b00;
            x_q        <= '0;
            y_q        <= '0;
            shadow_q   <= '0;
            cy_q       <= 1'b0;
            cnt_q      <= '0;
            bad_q      <= 1'b0;
            result_q   <= '0;
            overload_q <= 1'b0;
            invalid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            x_q        <= x_d;
            y_q        <= y_d;
            shadow_q   <= shadow_d;
            cy_q       <= cy_d;
            cnt_q      <= cnt_d;
            bad_q      <= bad_d;
            result_q   <= result_d;
            overload_q <= overload_d;
            invalid_q  <= invalid_d;
        end
    end

    // One glyph per result digit
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_glyph
            assign glyphs[7*gi +: 7] = seg7(result_q[4*gi +: 4]);
        end
    endgenerate

    assign bus.busy          = (state_q != S_IDLE);
    assign bus.done          = (state_q == S_DONE);
    assign bus.result        = result_q;
    assign bus.overload      = overload_q;
    assign bus.invalid       = invalid_q;
    assign bus.digits_result = glyphs;
endmodule

// File: tb/tb_sum_ndigit_alu.sv
// Directed bench for sum_ndigit_alu.
// Two instances with DIGITS=4 are used: dut0 in hex mode (BCD=0) and dut1 in BCD mode (BCD=1).
module tb_sum_ndigit_alu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    sum_ndigit_alu_if #(.DIGITS(4)) bus0 ();
    sum_ndigit_alu_if #(.DIGITS(4)) bus1 ();

    sum_ndigit_alu #(.DIGITS(4), .BCD(1'b0)) dut0 (.clock(clk), .reset(rst), .bus(bus0));
    sum_ndigit_alu #(.DIGITS(4), .BCD(1'b1)) dut1 (.clock(clk), .reset(rst), .bus(bus1));

    // Issue one operation on bus <sel> and wait, with a bound, for done.
    // lat counts falling edges from the start drive until done is seen.
    task automatic run_op(input int sel, input logic [1:0] m, input logic [15:0] a,
                          input logic [15:0] b, output logic [15:0] r, output logic ov,
                          output logic inv, output int lat);
        @(negedge clk);
        if (sel == 0) begin
            bus0.start = 1'b1; bus0.mode = m; bus0.operand_a = a; bus0.operand_b = b;
        end else begin
            bus1.start = 1'b1; bus1.mode = m; bus1.operand_a = a; bus1.operand_b = b;
        end
        @(negedge clk);
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        lat = 1;
        while ((((sel == 0) ? bus0.done : bus1.done) !== 1'b1) && (lat < 40)) begin
            @(negedge clk);
            lat++;
        end
        r   = (sel == 0) ? bus0.result   : bus1.result;
        ov  = (sel == 0) ? bus0.overload : bus1.overload;
        inv = (sel == 0) ? bus0.invalid  : bus1.invalid;
        $display("op sel=%0d mode=%0d a=%h b=%h -> result=%h ov=%0b inv=%0b lat=%0d",
                 sel, m, a, b, r, ov, inv, lat);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        $display("reset: busy0=%0b done0=%0b result0=%h result1=%h", bus0.busy, bus0.done,
                 bus0.result, bus1.result);
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy0 got %b want 0", bus0.busy); end
        checks++; if (bus0.done !== 1'b0) begin errors++; $display("FAIL reset_done0 got %b want 0", bus0.done); end
        checks++; if (bus0.result !== 16'h0000) begin errors++; $display("FAIL reset_result0 got %h want 0000", bus0.result); end
        checks++; if (bus0.overload !== 1'b0) begin errors++; $display("FAIL reset_ov0 got %b want 0", bus0.overload); end
        checks++; if (bus1.invalid !== 1'b0) begin errors++; $display("FAIL reset_inv1 got %b want 0", bus1.invalid); end
        checks++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy1 got %b want 0", bus1.busy); end
        checks++; if (bus0.digits_result !== {4{7'h3F}}) begin errors++; $display("FAIL reset_glyphs got %h want %h", bus0.digits_result, {4{7'h3F}}); end
    endtask

    // 0x1234 + 0x0FFF; checks latency and busy/done timing
    task automatic test_hex_add();
        int lat;
        int busy_cnt;
        lat = 0;
        busy_cnt = 0;
        @(negedge clk);
        bus0.start = 1'b1; bus0.mode = 2'b00; bus0.operand_a = 16'h1234; bus0.operand_b = 16'h0FFF;
        do begin
            @(negedge clk);
            bus0.start = 1'b0;
            lat++;
            if (bus0.busy === 1'b1 && bus0.done !== 1'b1) busy_cnt++;
        end while (bus0.done !== 1'b1 && lat < 40);
        $display("hex_add: result=%h ov=%0b lat=%0d busy_cycles=%0d", bus0.result, bus0.overload, lat, busy_cnt);
        checks++; if (lat != 6) begin errors++; $display("FAIL hex_add_latency got %0d want 6", lat); end
        checks++; if (busy_cnt != 5) begin errors++; $display("FAIL hex_add_busy_cycles got %0d want 5", busy_cnt); end
        checks++; if (bus0.busy !== 1'b1) begin errors++; $display("FAIL hex_add_busy_at_done got %b want 1", bus0.busy); end
        checks++; if (bus0.result !== 16'h2233) begin errors++; $display("FAIL hex_add_result got %h want 2233", bus0.result); end
        checks++; if (bus0.overload !== 1'b0) begin errors++; $display("FAIL hex_add_ov got %b want 0", bus0.overload); end
        checks++; if (bus0.digits_result !== {7'h5B, 7'h5B, 7'h4F, 7'h4F}) begin errors++; $display("FAIL hex_add_glyphs got %h want %h", bus0.digits_result, {7'h5B, 7'h5B, 7'h4F, 7'h4F}); end
        @(negedge clk);
        checks++; if (bus0.done !== 1'b0) begin errors++; $display("FAIL hex_add_done_pulse got %b want 0", bus0.done); end
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL hex_add_busy_after got %b want 0", bus0.busy); end
    endtask

    task automatic test_hex_overflow();
        logic [15:0] r; logic ov, inv; int lat;
        run_op(0, 2'b00, 16'hFFFF, 16'h0001, r, ov, inv, lat);
        checks++; if (r !== 16'h0000 || ov !== 1'b1) begin errors++; $display("FAIL hex_add_ovf got %h/%b want 0000/1", r, ov); end
        run_op(0, 2'b01, 16'h0000, 16'h0001, r, ov, inv, lat);
        checks++; if (r !== 16'hFFFF || ov !== 1'b1) begin errors++; $display("FAIL hex_sub_underflow got %h/%b want FFFF/1", r, ov); end
        run_op(0, 2'b01, 16'h5000, 16'h1234, r, ov, inv, lat);
        checks++; if (r !== 16'h3DCC || ov !== 1'b0) begin errors++; $display("FAIL hex_sub got %h/%b want 3DCC/0", r, ov); end
        run_op(0, 2'b00, 16'h00A0, 16'h0001, r, ov, inv, lat);
        checks++; if (r !== 16'h00A1 || inv !== 1'b0) begin errors++; $display("FAIL hex_no_invalid got %h/%b want 00A1/0", r, inv); end
    endtask

    task automatic test_bcd_arith();
        logic [15:0] r; logic ov, inv; int lat;
        run_op(1, 2'b01, 16'h0100, 16'h0001, r, ov, inv, lat);
        checks++; if (r !== 16'h0099 || ov !== 1'b0) begin errors++; $display("FAIL bcd_sub got %h/%b want 0099/0", r, ov); end
        checks++; if (lat != 6) begin errors++; $display("FAIL bcd_latency got %0d want 6", lat); end
        run_op(1, 2'b01, 16'h0000, 16'h0001, r, ov, inv, lat);
        checks++; if (r !== 16'h9999 || ov !== 1'b1) begin errors++; $display("FAIL bcd_sub_underflow got %h/%b want 9999/1", r, ov); end
        run_op(1, 2'b00, 16'h9999, 16'h0001, r, ov, inv, lat);
        checks++; if (r !== 16'h0000 || ov !== 1'b1) begin errors++; $display("FAIL bcd_add_ovf got %h/%b want 0000/1", r, ov); end
        run_op(1, 2'b00, 16'h0458, 16'h0367, r, ov, inv, lat);
        checks++; if (r !== 16'h0825 || ov !== 1'b0) begin errors++; $display("FAIL bcd_add got %h/%b want 0825/0", r, ov); end
    endtask

    task automatic test_acc();
        logic [15:0] r; logic ov, inv; int lat;
        run_op(0, 2'b11, 16'h1234, 16'h5678, r, ov, inv, lat);
        checks++; if (r !== 16'h0000 || ov !== 1'b0) begin errors++; $display("FAIL hex_clear got %h/%b want 0000/0", r, ov); end
        checks++; if (lat != 6) begin errors++; $display("FAIL clear_latency got %0d want 6", lat); end
        repeat (3) run_op(0, 2'b10, 16'h0005, 16'h7777, r, ov, inv, lat);
        checks++; if (r !== 16'h000F || ov !== 1'b0) begin errors++; $display("FAIL hex_acc got %h/%b want 000F/0", r, ov); end
        run_op(1, 2'b11, 16'h0000, 16'h0000, r, ov, inv, lat);
        repeat (3) run_op(1, 2'b10, 16'h0005, 16'h0000, r, ov, inv, lat);
        checks++; if (r !== 16'h0015 || ov !== 1'b0) begin errors++; $display("FAIL bcd_acc5 got %h/%b want 0015/0", r, ov); end
        run_op(1, 2'b11, 16'h0000, 16'h0000, r, ov, inv, lat);
        repeat (2) run_op(1, 2'b10, 16'h0009, 16'h0000, r, ov, inv, lat);
        checks++; if (r !== 16'h0018) begin errors++; $display("FAIL bcd_acc9 got %h want 0018", r); end
    endtask

    task automatic test_back_to_back();
        int ndone;
        logic [15:0] r;
        ndone = 0;
        r = 16'hxxxx;
        @(negedge clk);
        bus0.start = 1'b1; bus0.mode = 2'b00; bus0.operand_a = 16'h0001; bus0.operand_b = 16'h0002;
        @(negedge clk);
        bus0.start = 1'b0;
        @(negedge clk);
        bus0.start = 1'b1; bus0.mode = 2'b01; bus0.operand_a = 16'h0009; bus0.operand_b = 16'h0009;
        @(negedge clk);
        bus0.start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus0.done === 1'b1) begin ndone++; r = bus0.result; end
        end
        $display("back_to_back: dones=%0d result=%h", ndone, r);
        checks++; if (ndone != 1) begin errors++; $display("FAIL b2b_done_count got %0d want 1", ndone); end
        checks++; if (r !== 16'h0003) begin errors++; $display("FAIL b2b_result got %h want 0003", r); end

        // Abort with reset while CALC is running
        @(negedge clk);
        bus0.start = 1'b1; bus0.mode = 2'b00; bus0.operand_a = 16'h1111; bus0.operand_b = 16'h1111;
        @(negedge clk);
        bus0.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        $display("reset_mid_op: busy=%0b done=%0b result=%h", bus0.busy, bus0.done, bus0.result);
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", bus0.busy); end
        checks++; if (bus0.result !== 16'h0000) begin errors++; $display("FAIL abort_result got %h want 0000", bus0.result); end
        checks++; if (bus0.overload !== 1'b0) begin errors++; $display("FAIL abort_ov got %b want 0", bus0.overload); end
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus0.done === 1'b1) ndone++;
        end
        checks++; if (ndone != 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", ndone); end
    endtask

    task automatic test_invalid();
        logic [15:0] r; logic ov, inv; int lat;
        run_op(1, 2'b00, 16'h9990, 16'h0020, r, ov, inv, lat);
        checks++; if (r !== 16'h0010 || ov !== 1'b1) begin errors++; $display("FAIL bcd_pre_invalid got %h/%b want 0010/1", r, ov); end
        run_op(1, 2'b00, 16'h00A0, 16'h0001, r, ov, inv, lat);
        checks++; if (inv !== 1'b1) begin errors++; $display("FAIL invalid_flag got %b want 1", inv); end
        checks++; if (r !== 16'h0010) begin errors++; $display("FAIL invalid_result_kept got %h want 0010", r); end
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL invalid_ov got %b want 0", ov); end
        checks++; if (lat != 6) begin errors++; $display("FAIL invalid_done_latency got %0d want 6", lat); end
        run_op(1, 2'b00, 16'h0001, 16'h0001, r, ov, inv, lat);
        checks++; if (r !== 16'h0002 || inv !== 1'b0) begin errors++; $display("FAIL after_invalid got %h/%b want 0002/0", r, inv); end
        checks++; if (bus1.digits_result[6:0] !== 7'h5B) begin errors++; $display("FAIL glyph_digit0 got %h want 5B", bus1.digits_result[6:0]); end
        checks++; if (bus1.digits_result[13:7] !== 7'h3F) begin errors++; $display("FAIL glyph_digit1 got %h want 3F", bus1.digits_result[13:7]); end
    endtask

    initial begin
        bus0.start = 1'b0; bus0.mode = 2'b00; bus0.operand_a = '0; bus0.operand_b = '0;
        bus1.start = 1'b0; bus1.mode = 2'b00; bus1.operand_a = '0; bus1.operand_b = '0;
        test_reset();
        test_hex_add();
        test_hex_overflow();
        test_bcd_arith();
        test_acc();
        test_back_to_back();
        test_invalid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
